// File: rtl/intpol2_d4_sched_pkg.sv
// Control package for the quadratic x4 interpolation sequencer.
// Holds the FSM state encoding, the status-byte bit positions, the number of
// interpolation phases per input sample, and a helper that decides whether
// the current issue is the last one for the sample in flight.
package intpol2_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_LOAD   = 3'd3,
    ST_INTERP = 3'd4,
    ST_DRAIN  = 3'd5
  } state_e;

  // Status byte bit positions
  localparam int unsigned DONE       = 0;
  localparam int unsigned BUSY       = 1;
  localparam int unsigned STOP_EMPTY = 2;
  localparam int unsigned STOP_AFULL = 3;
  localparam int unsigned BYPASS     = 5;

  // Interpolation phases per input sample and the width of the phase index
  localparam int unsigned D    = 4;
  localparam int unsigned PH_W = $clog2(D);

  // The 3-tap history needs two samples loaded before the first issue.
  localparam logic [1:0] PRIME_TAPS = 2'd2;
  localparam logic [1:0] PRIME_LAST = 2'd1;

  // True when the issue at this phase completes the current input sample.
  function automatic logic sample_last(input logic bypass,
                                       input logic [PH_W-1:0] phase);
    return bypass || (phase == PH_W'(D - 1));
  endfunction

endpackage

// File: rtl/intpol2_d4_sched_if.sv
// Handshake bundle between the sequencer and its surroundings (AIP start and
// config registers, input FIFO flags, downstream flags, datapath strobes).
//   start/cfg_num_samples/cfg_bypass : job launch and configuration
//   empty_i/afull_i                  : input FIFO empty, downstream almost-full
//   rd_en_o/load_o                   : FIFO read and tap-history load
//   issue_o/phase_o                  : datapath issue and mu index
//   wr_en_o                          : output write strobe (issue delayed)
//   status_o/done_o                  : status byte and completion pulse
// modport slave is the sequencer, modport master is the environment.
interface intpol2_d4_sched_if #(
  parameter int CNT_WIDTH = 16
) ();
  import intpol2_ctrl_pkg::*;

  logic                 start;
  logic [CNT_WIDTH-1:0] cfg_num_samples;
  logic                 cfg_bypass;
  logic                 empty_i;
  logic                 afull_i;
  logic                 rd_en_o;
  logic                 load_o;
  logic                 issue_o;
  logic [PH_W-1:0]      phase_o;
  logic                 wr_en_o;
  logic [7:0]           status_o;
  logic                 done_o;

  modport master (
    output start, cfg_num_samples, cfg_bypass, empty_i, afull_i,
    input  rd_en_o, load_o, issue_o, phase_o, wr_en_o, status_o, done_o
  );

  modport slave (
    input  start, cfg_num_samples, cfg_bypass, empty_i, afull_i,
    output rd_en_o, load_o, issue_o, phase_o, wr_en_o, status_o, done_o
  );

endinterface

// File: rtl/intpol2_d4_sched_valid_dly.sv
// Strobe delay line matching the interpolation datapath latency.
//   clk       : clock, posedge
//   rst_a     : asynchronous active-high clear
//   vld_i     : issue strobe entering the datapath
//   vld_o     : the same strobe PIPE_LAT cycles later (output write enable)
//   pending_o : some strobe is still travelling through the line
module intpol2_valid_dly #(
  parameter int PIPE_LAT = 3
) (
  input  logic clk,
  input  logic rst_a,
  input  logic vld_i,
  output logic vld_o,
  output logic pending_o
);

  logic [PIPE_LAT-1:0] dly_q;
  logic [PIPE_LAT-1:0] dly_d;

  generate
    if (PIPE_LAT == 1) begin : g_one
      always_comb dly_d = vld_i;
    end else begin : g_multi
      always_comb dly_d = {dly_q[PIPE_LAT-2:0], vld_i};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) dly_q <= '0;
    else       dly_q <= dly_d;
  end

  assign vld_o     = dly_q[PIPE_LAT-1];
  assign pending_o = |dly_q;

endmodule

// File: rtl/intpol2_d4_sched.sv
// Sequencer for the quadratic x4 interpolation datapath.
// Pulls I/Q pairs from the input FIFOs, primes the 3-tap history, issues four
// phases per input sample (one in bypass), delays the issue strobe to form the
// output write enable, and reports progress in the AIP status byte.
//   clk   : clock, posedge
//   rst_a : asynchronous active-high reset
//   bus   : handshake bundle (slave side), see intpol2_d4_sched_if
module intpol2_d4_sched
  import intpol2_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int PIPE_LAT  = 3
) (
  input  logic              clk,
  input  logic              rst_a,
  intpol2_d4_sched_if.slave bus
);

  state_e               state_q,      state_d;
  logic [CNT_WIDTH-1:0] num_q,        num_d;
  logic [CNT_WIDTH-1:0] cnt_q,        cnt_d;
  logic                 bypass_q,     bypass_d;
  logic [PH_W-1:0]      phase_q,      phase_d;
  logic [1:0]           prime_q,      prime_d;
  logic                 done_q,       done_d;
  logic                 sdone_q,      sdone_d;
  logic                 stop_empty_q, stop_empty_d;
  logic                 stop_afull_q, stop_afull_d;

  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 rd_en;
  logic                 load;
  logic                 issue;
  logic [PH_W-1:0]      phase;
  logic [7:0]           status;
  logic                 wr_en;
  logic                 pending;

  assign cnt_inc = cnt_q + 1'b1;

  // State and job registers
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q      <= ST_IDLE;
      num_q        <= '0;
      cnt_q        <= '0;
      bypass_q     <= 1'b0;
      phase_q      <= '0;
      prime_q      <= '0;
      done_q       <= 1'b0;
      sdone_q      <= 1'b0;
      stop_empty_q <= 1'b0;
      stop_afull_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      cnt_q        <= cnt_d;
      bypass_q     <= bypass_d;
      phase_q      <= phase_d;
      prime_q      <= prime_d;
      done_q       <= done_d;
      sdone_q      <= sdone_d;
      stop_empty_q <= stop_empty_d;
      stop_afull_q <= stop_afull_d;
    end
  end

  // Next-state and job bookkeeping
  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    cnt_d        = cnt_q;
    bypass_d     = bypass_q;
    phase_d      = phase_q;
    prime_d      = prime_q;
    done_d       = 1'b0;
    sdone_d      = sdone_q;
    stop_empty_d = stop_empty_q;
    stop_afull_d = stop_afull_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          num_d        = bus.cfg_num_samples;
          bypass_d     = bus.cfg_bypass;
          cnt_d        = '0;
          phase_d      = '0;
          // Bypass needs no history, so it starts with priming complete.
          prime_d      = bus.cfg_bypass ? PRIME_TAPS : 2'd0;
          sdone_d      = 1'b0;
          stop_empty_d = 1'b0;
          stop_afull_d = 1'b0;
          if (bus.cfg_num_samples == '0) begin
            done_d  = 1'b1;
            sdone_d = 1'b1;
          end else begin
            state_d = bus.cfg_bypass ? ST_FETCH : ST_PRIME;
          end
        end
      end

      // PRIME is the fetch step used while filling the history.
      ST_PRIME, ST_FETCH: begin
        stop_empty_d = bus.empty_i;
        if (!bus.empty_i) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        phase_d = '0;
        if (prime_q != PRIME_TAPS) begin
          prime_d = prime_q + 2'd1;
          state_d = (prime_q == PRIME_LAST) ? ST_FETCH : ST_PRIME;
        end else begin
          state_d = ST_INTERP;
        end
      end

      ST_INTERP: begin
        stop_afull_d = bus.afull_i;
        if (!bus.afull_i) begin
          if (sample_last(bypass_q, phase_q)) begin
            cnt_d   = cnt_inc;
            phase_d = '0;
            state_d = (cnt_inc == num_q) ? ST_DRAIN : ST_FETCH;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (!pending) begin
          done_d  = 1'b1;
          sdone_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    rd_en  = 1'b0;
    load   = 1'b0;
    issue  = 1'b0;
    phase  = '0;
    status = '0;

    rd_en = ((state_q == ST_PRIME) || (state_q == ST_FETCH)) && !bus.empty_i;
    load  = (state_q == ST_LOAD);
    issue = (state_q == ST_INTERP) && !bus.afull_i;
    phase = issue ? phase_q : '0;

    status[DONE]       = sdone_q;
    status[BUSY]       = (state_q != ST_IDLE);
    status[STOP_EMPTY] = stop_empty_q;
    status[STOP_AFULL] = stop_afull_q;
    status[BYPASS]     = bypass_q;
  end

  // Issue strobe to write enable, aligned with datapath latency
  intpol2_valid_dly #(
    .PIPE_LAT (PIPE_LAT)
  ) u_valid_dly (
    .clk       (clk),
    .rst_a     (rst_a),
    .vld_i     (issue),
    .vld_o     (wr_en),
    .pending_o (pending)
  );

  assign bus.rd_en_o  = rd_en;
  assign bus.load_o   = load;
  assign bus.issue_o  = issue;
  assign bus.phase_o  = phase;
  assign bus.wr_en_o  = wr_en;
  assign bus.status_o = status;
  assign bus.done_o   = done_q;

endmodule

// File: tb/tb_intpol2_d4_sched.sv
// Testbench for intpol2_d4_sched: directed scenarios plus randomized jobs,
// checked every cycle against a job-level behavioural model.
module tb_intpol2_d4_sched;

  localparam int CW  = 16;
  localparam int LAT = 3;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;

  intpol2_d4_sched_if #(.CNT_WIDTH(CW)) ifc ();

  intpol2_d4_sched #(
    .CNT_WIDTH (CW),
    .PIPE_LAT  (LAT)
  ) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- environment flags ----------------
  int empty_hold = 0;
  int afull_hold = 0;
  int p_empty    = 0;
  int p_afull    = 0;

  initial begin
    ifc.empty_i = 1'b0;
    ifc.afull_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ifc.empty_i = (empty_hold > 0) ||
                    (p_empty > 0 && int'($urandom_range(99)) < p_empty);
      ifc.afull_i = (afull_hold > 0) ||
                    (p_afull > 0 && int'($urandom_range(99)) < p_afull);
      if (empty_hold > 0) empty_hold--;
      if (afull_hold > 0) afull_hold--;
    end
  end

  // ---------------- behavioural model + compare ----------------
  longint cyc       = 0;
  bit     active    = 0;
  bit     st0       = 0;
  bit     byp_l     = 0;
  bit     zero_due  = 0;
  int     n_job     = 0;
  bit     byp_job   = 0;
  int     reads     = 0;
  int     loads     = 0;
  int     issues    = 0;
  int     writes    = 0;
  longint last_iss  = 0;
  longint start_cyc = 0;
  int     done_cnt  = 0;
  bit     prev_rd = 0, prev_empty = 0, prev_afull = 0, prev_issue = 0;
  bit     hist[LAT];
  longint p0_cyc[$];
  bit     arm_empty = 0;
  bit     arm_afull = 0;
  longint empty_c   = -100;
  longint afull_c   = -100;

  initial begin
    for (int k = 0; k < LAT; k++) hist[k] = 0;
    forever begin
      int exp_r, exp_w;
      @(negedge clk);
      if (rst_a) begin
        active = 0; st0 = 0; byp_l = 0; zero_due = 0;
        prev_rd = 0; prev_empty = 0; prev_afull = 0; prev_issue = 0;
        for (int k = 0; k < LAT; k++) hist[k] = 0;
        continue;
      end
      cyc++;
      exp_r = byp_job ? n_job : n_job + 2;
      exp_w = byp_job ? n_job : 4 * n_job;

      // write strobe is the issue strobe LAT cycles earlier
      chk("wr_en_latency", ifc.wr_en_o, hist[LAT-1]);
      if (ifc.wr_en_o) writes++;

      if (ifc.done_o) begin
        chk("done_expected", active || zero_due, 1);
        if (zero_due) begin
          chk("n0_done_delay", cyc - start_cyc, 1);
          chk("n0_no_reads", reads, 0);
        end else if (active) begin
          chk("job_reads", reads, exp_r);
          chk("job_loads", loads, exp_r);
          chk("job_issues", issues, exp_w);
          chk("job_writes", writes, exp_w);
          chk("done_gap_ge_lat", (cyc - last_iss) >= LAT, 1);
        end
        active = 0;
        st0    = 1;
        done_cnt++;
      end else if (zero_due) begin
        chk("n0_done_missing", ifc.done_o, 1);
      end
      zero_due = 0;

      chk("status_busy", ifc.status_o[1], active);
      chk("status_done", ifc.status_o[0], st0);
      chk("status_bypass", ifc.status_o[5], byp_l);
      chk("status_zero_bits", {ifc.status_o[7:6], ifc.status_o[4]}, 0);
      chk("stop_empty_src", ifc.status_o[2] & ~prev_empty, 0);
      chk("stop_empty_clr", ifc.status_o[2] & prev_rd, 0);
      chk("stop_afull_src", ifc.status_o[3] & ~prev_afull, 0);
      chk("stop_afull_clr", ifc.status_o[3] & prev_issue, 0);

      if (cyc >= empty_c + 3 && cyc <= empty_c + 11)
        chk("hold_stop_empty", ifc.status_o[2], 1);
      if (cyc == empty_c + 11) chk("hold_resume_rd", ifc.rd_en_o, 1);
      if (cyc >= afull_c + 2 && cyc <= afull_c + 6)
        chk("afull_stop_bit", ifc.status_o[3], 1);
      if (cyc == afull_c + LAT) chk("afull_inflight_wr", ifc.wr_en_o, 1);
      if (cyc == afull_c + 6) begin
        chk("afull_resume_issue", ifc.issue_o, 1);
        chk("afull_resume_phase", ifc.phase_o, 2);
      end

      chk("load_after_rd", ifc.load_o, prev_rd);
      if (ifc.load_o) loads++;

      if (ifc.rd_en_o) begin
        chk("rd_needs_data", ifc.empty_i, 0);
        chk("rd_in_job", active, 1);
        reads++;
        chk("rd_bound", reads > exp_r, 0);
        if (arm_empty) begin
          arm_empty = 0; empty_hold = 10; empty_c = cyc;
        end
      end

      if (ifc.issue_o) begin
        chk("issue_not_afull", ifc.afull_i, 0);
        chk("issue_in_job", active, 1);
        chk("issue_phase", ifc.phase_o, byp_job ? 0 : issues % 4);
        if (ifc.phase_o == 0) p0_cyc.push_back(cyc);
        issues++;
        chk("issue_bound", issues > exp_w, 0);
        last_iss = cyc;
        if (arm_afull && ifc.phase_o == 1) begin
          arm_afull = 0; afull_hold = 5; afull_c = cyc;
        end
      end

      if (ifc.start && !active) begin
        n_job   = int'(ifc.cfg_num_samples);
        byp_job = ifc.cfg_bypass;
        byp_l   = ifc.cfg_bypass;
        st0     = 0;
        reads = 0; loads = 0; issues = 0; writes = 0;
        p0_cyc.delete();
        start_cyc = cyc;
        if (n_job == 0) zero_due = 1;
        else            active   = 1;
      end

      prev_rd    = ifc.rd_en_o;
      prev_empty = ifc.empty_i;
      prev_afull = ifc.afull_i;
      prev_issue = ifc.issue_o;
      for (int k = LAT - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = ifc.issue_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic launch(input int n, input bit b);
    @(posedge clk); #1;
    ifc.cfg_num_samples = CW'(n);
    ifc.cfg_bypass      = b;
    ifc.start           = 1'b1;
    @(posedge clk); #1;
    ifc.start           = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("job_completes", done_cnt != d0, 1);
  endtask

  task automatic wait_issues(input int n);
    int k = 0;
    while (issues < n && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("issues_reached", issues >= n, 1);
  endtask

  task automatic run_job(input int n, input bit b);
    int d0 = done_cnt;
    launch(n, b);
    wait_done(d0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd"},     ifc.rd_en_o, 0);
    chk({tag, "_load"},   ifc.load_o, 0);
    chk({tag, "_issue"},  ifc.issue_o, 0);
    chk({tag, "_phase"},  ifc.phase_o, 0);
    chk({tag, "_wr"},     ifc.wr_en_o, 0);
    chk({tag, "_status"}, ifc.status_o, 0);
    chk({tag, "_done"},   ifc.done_o, 0);
  endtask

  initial begin
    int d0;
    ifc.start = 1'b0;
    ifc.cfg_num_samples = '0;
    ifc.cfg_bypass = 1'b0;

    rst_a = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_outputs_zero("reset");
    @(negedge clk); #1;
    rst_a = 1'b0;
    repeat (2) @(posedge clk);

    // N=3 interp, no stalls
    run_job(3, 1'b0);
    chk("t1_reads", reads, 5);
    chk("t1_loads", loads, 5);
    chk("t1_writes", writes, 12);
    chk("t1_samples", p0_cyc.size(), 3);
    for (int i = 1; i < p0_cyc.size(); i++)
      chk("t1_spacing", p0_cyc[i] - p0_cyc[i-1], 6);
    @(negedge clk); #1;
    chk("t1_status_end", ifc.status_o, 8'h01);

    // N=4 bypass
    d0 = done_cnt;
    launch(4, 1'b1);
    wait_issues(1);
    chk("t2_status_run", ifc.status_o, 8'h22);
    wait_done(d0);
    chk("t2_reads", reads, 4);
    chk("t2_writes", writes, 4);
    chk("t2_samples", p0_cyc.size(), 4);
    for (int i = 1; i < p0_cyc.size(); i++)
      chk("t2_spacing", p0_cyc[i] - p0_cyc[i-1], 3);

    // N=2 interp, input empty for 10 cycles after the first read
    arm_empty = 1;
    run_job(2, 1'b0);
    chk("t3_hold_seen", empty_c > 0, 1);
    chk("t3_reads", reads, 4);
    chk("t3_writes", writes, 8);

    // afull for 5 cycles starting at phase 2
    arm_afull = 1;
    run_job(2, 1'b0);
    chk("t4_afull_seen", afull_c > 0, 1);
    chk("t4_writes", writes, 8);

    // N=0
    run_job(0, 1'b0);
    chk("t5_reads", reads, 0);
    @(negedge clk); #1;
    chk("t5_status", ifc.status_o, 8'h01);

    // async reset in the middle of INTERP, then a fresh N=1 job
    launch(3, 1'b0);
    wait_issues(2);
    @(posedge clk); #3;
    rst_a = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    @(negedge clk);
    @(negedge clk); #1;
    rst_a = 1'b0;
    run_job(1, 1'b0);
    chk("t6_reads", reads, 3);
    chk("t6_writes", writes, 4);

    // randomized jobs with random stalls
    p_empty = 25;
    p_afull = 25;
    for (int j = 0; j < 8; j++) begin
      int n;
      bit b;
      n = int'($urandom_range(1, 6));
      b = 1'($urandom_range(0, 1));
      if (j == 2) begin
        // a start while the job runs must be ignored
        d0 = done_cnt;
        launch(n, b);
        wait_issues(1);
        @(posedge clk); #1;
        ifc.cfg_num_samples = CW'(9);
        ifc.cfg_bypass      = ~b;
        ifc.start           = 1'b1;
        @(posedge clk); #1;
        ifc.start           = 1'b0;
        wait_done(d0);
      end else begin
        run_job(n, b);
      end
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
    end
    p_empty = 0;
    p_afull = 0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/intpol2_d4_sched.md
# intpol2_d4_sched

Sequencer for the quadratic ×4 interpolation datapath. It pulls I/Q sample pairs from the input FIFOs, primes the 3‑tap history, issues four interpolation phases per input sample (one in bypass), and aligns the output write strobe with datapath latency. It stalls on empty input or almost‑full downstream and drives the core status byte read back through the AIP interface. It sits between the AIP start/config registers and the interpolation arithmetic.

## Interface
- `CNT_WIDTH`, 16, width of the sample‑count register
- `PIPE_LAT`, 3, datapath latency in cycles from `issue_o` to valid `I_interp`/`Q_interp`
- `clk` in 1, single clock, posedge
- `rst_a` in 1, asynchronous, active‑high reset
- `start` in 1, one‑cycle pulse from AIP start logic
- `cfg_num_samples` in CNT_WIDTH, input samples to process (N)
- `cfg_bypass` in 1, 1 = pass samples 1:1 without interpolation
- `empty_i` in 1, OR of I and Q FIFO empty flags
- `afull_i` in 1, OR of downstream almost‑full flags
- `rd_en_o` out 1, FIFO read enable (I and Q together)
- `load_o` out 1, shift FIFO output into tap history (FIFO data valid this cycle)
- `issue_o` out 1, datapath computes one output this cycle
- `phase_o` out 2, mu index 0..3 for the issued output
- `wr_en_o` out 1, output write enable, `issue_o` delayed PIPE_LAT
- `status_o` out 8, [0] done, [1] busy, [2] stop_empty, [3] stop_afull, [5] bypass; others 0
- `done_o` out 1, one‑cycle pulse at completion

## Operation
- States: IDLE, PRIME, FETCH, LOAD, INTERP, DRAIN.
- IDLE: `start` latches N and bypass and clears status[0]. If N==0, pulse `done_o` next cycle, set status[0], and stay in IDLE. Otherwise go to PRIME (interp) or FETCH (bypass). `start` outside IDLE is ignored.
- PRIME: perform two read/load pairs, using the same FETCH/LOAD sub‑sequence with prime count 0..1. Then go to FETCH. PRIME outputs nothing.
- FETCH: if `empty_i`, hold and set status[2]. Else assert `rd_en_o`, clear status[2], and go to LOAD.
- LOAD: assert `load_o`, then go to INTERP with phase=0.
- INTERP:
  - If `afull_i`, hold with no issue and set status[3].
  - Else assert `issue_o` with `phase_o`=phase and clear status[3].
  - Interp mode: phase increments 0→3. After phase 3, increment the sample count.
  - Bypass mode: one issue with phase 0, then increment the sample count.
  - When the count reaches N, go to DRAIN; otherwise go to FETCH.
- DRAIN: wait until the delay line holds no pending strobe. Then pulse `done_o`, set status[0], and go to IDLE.
- status[1] = (state != IDLE). status[5] = latched bypass.
- Totals per job:
  - Interp: N+2 reads and 4N writes.
  - Bypass: N reads and N writes.
- The count register wraps only via the compare to N. No overflow is possible since count ≤ N.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, delay line cleared. Reset is async at any time, including mid‑job; the FIFO contents are not this block's concern.
- `rd_en_o` in cycle t → `load_o` in t+1, since FIFO data is registered‑valid one cycle after read.
- `issue_o` in cycle t → `wr_en_o` in t+PIPE_LAT exactly. `afull_i` does not gate strobes already in flight.
- Steady state, interp: 6 cycles per input (FETCH, LOAD, 4×INTERP) → 4 writes.
- Steady state, bypass: 3 cycles per input.
- `done_o` fires PIPE_LAT cycles after the last issue at the earliest.
- `empty_i` and `afull_i` are sampled only in FETCH and INTERP respectively. Simultaneous assertion is irrelevant, because only the flag for the current state matters.
- stop bits are level status, not sticky. Both clear on `start`.

## Structure
- Package `intpol2_ctrl_pkg`: state enum, status bit index constants (DONE=0, BUSY=1, STOP_EMPTY=2, STOP_AFULL=3, BYPASS=5), and the phase count constant D=4.
- Sub‑module `intpol2_valid_dly`: PIPE_LAT‑deep shift register with async active‑high clear and an "any pending" output used by DRAIN.

## Test plan
- N=3, interp, FIFO preloaded with 5 pairs, no afull:
  - 5 `rd_en_o` and 5 `load_o`.
  - 12 `wr_en_o` with phases 0,1,2,3 repeating.
  - `done_o` 1 pulse; status ends 0x01.
- N=4, bypass:
  - 4 reads, 4 writes, all with phase 0.
  - 3‑cycle spacing between issues.
  - status during run 0x22.
- N=2, interp, FIFO empty for 10 cycles after the first read:
  - FSM holds in FETCH; status[2]=1 throughout the hold.
  - Resumes; total writes 8.
- `afull_i` high for 5 cycles during phase 2:
  - No `issue_o` while high; status[3]=1.
  - In‑flight `wr_en_o` still emerges.
  - Phase resumes at 2.
- N=0 start → `done_o` 1 cycle later, no reads, status 0x01.
- Assert `rst_a` mid‑INTERP → all outputs 0 immediately, IDLE; a new start with N=1 yields 3 reads and 4 writes.
